// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : MEM-stage load/store adapter onto a word-only data memory;
//               sub-word stores by read-modify-write, misalignment errors.
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit #(
    parameter int ADDR_W     = 10,
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [31:0]       resp_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [31:0]       mem_rdata
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ACCESS = 3'd1;
    localparam logic [2:0] S_RMW_RD = 3'd2;
    localparam logic [2:0] S_RMW_WR = 3'd3;
    localparam logic [2:0] S_RESP   = 3'd4;
    localparam logic [2:0] S_ERR    = 3'd5;

    localparam logic [1:0] c_SZ_BYTE = 2'd0;
    localparam logic [1:0] c_SZ_HALF = 2'd1;
    localparam logic [1:0] c_SZ_WORD = 2'd2;

    logic [2:0]        r_state;
    logic [2:0]        w_next;
    logic              r_write;
    logic              r_signed;
    logic [1:0]        r_size;
    logic [1:0]        r_off;
    logic [15:0]       r_wdata;
    logic [31:0]       r_rdata;
    logic [31:0]       r_mem_wdata;
    logic [ADDR_W-1:0] r_mem_addr;

    logic              w_accept;
    logic              w_req_err;
    logic [1:0]        w_lane;
    logic [4:0]        w_shift;
    logic [31:0]       w_lane_data;
    logic [31:0]       w_load;
    logic [31:0]       w_mask;
    logic [31:0]       w_merge;
    logic              w_unused_addr;

    assign w_unused_addr = ^req_addr[31:ADDR_W+2];

    assign w_accept  = (r_state == S_IDLE) && req_valid;
    assign w_req_err = (req_size == 2'd3)
                     || ((req_size == c_SZ_HALF) && req_addr[0])
                     || ((req_size == c_SZ_WORD) && (req_addr[1:0] != 2'd0));

    // Lane index counts bytes up from bit 0; big-endian mirrors the offset.
    always_comb begin
        w_lane = 2'd0;
        if (r_size == c_SZ_BYTE) begin
            w_lane = BIG_ENDIAN ? (2'd3 - r_off) : r_off;
        end else if (r_size == c_SZ_HALF) begin
            w_lane = BIG_ENDIAN ? (2'd2 - r_off) : r_off;
        end
    end

    assign w_shift     = {w_lane, 3'b000};
    assign w_lane_data = mem_rdata >> w_shift;

    always_comb begin
        w_load = mem_rdata;
        case (r_size)
            c_SZ_BYTE: w_load = {{24{r_signed & w_lane_data[7]}},  w_lane_data[7:0]};
            c_SZ_HALF: w_load = {{16{r_signed & w_lane_data[15]}}, w_lane_data[15:0]};
            default:   w_load = mem_rdata;
        endcase
    end

    assign w_mask  = (r_size == c_SZ_BYTE) ? 32'h0000_00FF : 32'h0000_FFFF;
    assign w_merge = (mem_rdata & ~(w_mask << w_shift))
                   | (({16'h0000, r_wdata} & w_mask) << w_shift);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    if (w_req_err)
                        w_next = S_ERR;
                    else if (!req_write || (req_size == c_SZ_WORD))
                        w_next = S_ACCESS;
                    else
                        w_next = S_RMW_RD;
                end
            end
            S_ACCESS: w_next = S_RESP;
            S_RMW_RD: w_next = S_RMW_WR;
            S_RMW_WR: w_next = S_RESP;
            S_RESP:   w_next = S_IDLE;
            S_ERR:    w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_write     <= 1'b0;
            r_signed    <= 1'b0;
            r_size      <= 2'd0;
            r_off       <= 2'd0;
            r_wdata     <= 16'h0000;
            r_rdata     <= 32'h0000_0000;
            r_mem_wdata <= 32'h0000_0000;
            r_mem_addr  <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_write  <= req_write;
                r_signed <= req_signed;
                r_size   <= req_size;
                r_off    <= req_addr[1:0];
                r_wdata  <= req_wdata[15:0];
                // Rejected requests leave the memory-side bus untouched.
                if (!w_req_err)
                    r_mem_addr <= req_addr[ADDR_W+1:2];
                if (!w_req_err && req_write && (req_size == c_SZ_WORD))
                    r_mem_wdata <= req_wdata;
                if (req_write || w_req_err)
                    r_rdata <= 32'h0000_0000;
            end
            if ((r_state == S_ACCESS) && !r_write)
                r_rdata <= w_load;
            if (r_state == S_RMW_RD)
                r_mem_wdata <= w_merge;
        end
    end

    assign req_ready  = (r_state == S_IDLE);
    assign resp_valid = (r_state == S_RESP) || (r_state == S_ERR);
    assign resp_err   = (r_state == S_ERR);
    assign resp_rdata = r_rdata;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign mem_we     = ((r_state == S_ACCESS) && r_write) || (r_state == S_RMW_WR);
    assign mem_re     = ((r_state == S_ACCESS) && !r_write) || (r_state == S_RMW_RD);

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_store_unit
// Description : Directed vector bench for load_store_unit with a word memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_write = 1'b0;
    logic [1:0]        req_size = 2'd0;
    logic              req_signed = 1'b0;
    logic [31:0]       req_addr = 32'h0;
    logic [31:0]       req_wdata = 32'h0;
    logic              resp_valid;
    logic              resp_err;
    logic [31:0]       resp_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_we;
    logic              mem_re;
    logic [31:0]       mem_rdata;

    logic [31:0] mem [0:(1<<ADDR_W)-1];
    int total = 0;
    int bad = 0;
    int both_strobes = 0;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_W(ADDR_W), .BIG_ENDIAN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_err(resp_err),
        .resp_rdata(resp_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata)
    );

    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;
    always @(negedge clk) if (mem_we && mem_re) both_strobes++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        wr;
        logic [1:0]  sz;
        logic        sg;
        logic [31:0] ad;
        logic [31:0] wd;
        logic        err;
        logic [31:0] rd;
        int          lat;
        int          nwe;
        int          nre;
        logic [31:0] ewd;
    } vec_t;

    // Issue one request and follow it to its response, sampling at negedges.
    task automatic do_req(input logic wr, input logic [1:0] sz, input logic sg,
                          input logic [31:0] ad, input logic [31:0] wd,
                          output logic [31:0] rd, output logic er, output int lat,
                          output int nwe, output int nre,
                          output logic [31:0] acc_addr, output logic [31:0] we_data);
        int  n;
        bit  done;
        @(negedge clk);
        req_write = wr; req_size = sz; req_signed = sg; req_addr = ad; req_wdata = wd;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rd = 32'hxxxx_xxxx; er = 1'bx; lat = 0; nwe = 0; nre = 0;
        acc_addr = 32'h0; we_data = 32'h0;
        done = 1'b0;
        for (int c = 1; c <= 8 && !done; c++) begin
            if (mem_we) begin nwe++; we_data = mem_wdata; end
            if (mem_re) nre++;
            if (mem_we || mem_re) acc_addr = {22'h0, mem_addr};
            if (resp_valid) begin
                lat = c; rd = resp_rdata; er = resp_err; done = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
    endtask

    vec_t vecs [0:20];

    initial begin : main
        logic [31:0] rd, acc_addr, we_data;
        logic        er;
        int          lat, nwe, nre;
        int          pulses, last, mingap, accepted, bad_ready, rst_resp;
        logic [31:0] hs_addr [0:2];
        logic [31:0] hs_exp  [0:2];

        vecs[0]  = '{1'b1, 2'd2, 1'b0, 32'h10,   32'hDEADBEEF, 1'b0, 32'h0,        2, 1, 0, 32'hDEADBEEF};
        vecs[1]  = '{1'b0, 2'd2, 1'b0, 32'h10,   32'h0,        1'b0, 32'hDEADBEEF, 2, 0, 1, 32'h0};
        vecs[2]  = '{1'b1, 2'd2, 1'b0, 32'h10,   32'h80FF7F01, 1'b0, 32'h0,        2, 1, 0, 32'h80FF7F01};
        vecs[3]  = '{1'b0, 2'd0, 1'b1, 32'h10,   32'h0,        1'b0, 32'hFFFFFF80, 2, 0, 1, 32'h0};
        vecs[4]  = '{1'b0, 2'd0, 1'b0, 32'h11,   32'h0,        1'b0, 32'h000000FF, 2, 0, 1, 32'h0};
        vecs[5]  = '{1'b0, 2'd0, 1'b1, 32'h12,   32'h0,        1'b0, 32'h0000007F, 2, 0, 1, 32'h0};
        vecs[6]  = '{1'b0, 2'd1, 1'b0, 32'h12,   32'h0,        1'b0, 32'h00007F01, 2, 0, 1, 32'h0};
        vecs[7]  = '{1'b0, 2'd1, 1'b1, 32'h10,   32'h0,        1'b0, 32'hFFFF80FF, 2, 0, 1, 32'h0};
        vecs[8]  = '{1'b0, 2'd2, 1'b1, 32'h10,   32'h0,        1'b0, 32'h80FF7F01, 2, 0, 1, 32'h0};
        vecs[9]  = '{1'b1, 2'd2, 1'b0, 32'h10,   32'h11223344, 1'b0, 32'h0,        2, 1, 0, 32'h11223344};
        vecs[10] = '{1'b1, 2'd0, 1'b0, 32'h13,   32'h123456AA, 1'b0, 32'h0,        3, 1, 1, 32'h112233AA};
        vecs[11] = '{1'b0, 2'd2, 1'b0, 32'h10,   32'h0,        1'b0, 32'h112233AA, 2, 0, 1, 32'h0};
        vecs[12] = '{1'b0, 2'd1, 1'b0, 32'h11,   32'h0,        1'b1, 32'h0,        1, 0, 0, 32'h0};
        vecs[13] = '{1'b1, 2'd2, 1'b0, 32'h12,   32'h55555555, 1'b1, 32'h0,        1, 0, 0, 32'h0};
        vecs[14] = '{1'b0, 2'd2, 1'b0, 32'h10,   32'h0,        1'b0, 32'h112233AA, 2, 0, 1, 32'h0};
        vecs[15] = '{1'b1, 2'd1, 1'b0, 32'h10,   32'h0000CAFE, 1'b0, 32'h0,        3, 1, 1, 32'hCAFE33AA};
        vecs[16] = '{1'b0, 2'd2, 1'b0, 32'h1010, 32'h0,        1'b0, 32'hCAFE33AA, 2, 0, 1, 32'h0};
        vecs[17] = '{1'b0, 2'd3, 1'b0, 32'h10,   32'h0,        1'b1, 32'h0,        1, 0, 0, 32'h0};
        vecs[18] = '{1'b0, 2'd0, 1'b1, 32'h11,   32'h0,        1'b0, 32'hFFFFFFFE, 2, 0, 1, 32'h0};
        vecs[19] = '{1'b1, 2'd0, 1'b0, 32'h10,   32'h0000007F, 1'b0, 32'h0,        3, 1, 1, 32'h7FFE33AA};
        vecs[20] = '{1'b0, 2'd2, 1'b0, 32'h10,   32'h0,        1'b0, 32'h7FFE33AA, 2, 0, 1, 32'h0};

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        check("rst_resp_err",   {31'h0, resp_err},   32'h0);
        check("rst_mem_we",     {31'h0, mem_we},     32'h0);
        check("rst_mem_re",     {31'h0, mem_re},     32'h0);
        check("rst_resp_rdata", resp_rdata,          32'h0);
        check("rst_mem_addr",   {22'h0, mem_addr},   32'h0);
        check("rst_mem_wdata",  mem_wdata,           32'h0);
        check("rst_req_ready",  {31'h0, req_ready},  32'h1);
        rst_n = 1'b1;

        for (int i = 0; i <= 20; i++) begin
            do_req(vecs[i].wr, vecs[i].sz, vecs[i].sg, vecs[i].ad, vecs[i].wd,
                   rd, er, lat, nwe, nre, acc_addr, we_data);
            check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
            check($sformatf("v%0d_err", i),     {31'h0, er}, {31'h0, vecs[i].err});
            check($sformatf("v%0d_rdata", i),   rd, vecs[i].rd);
            check($sformatf("v%0d_we_cycles", i), nwe, vecs[i].nwe);
            check($sformatf("v%0d_re_cycles", i), nre, vecs[i].nre);
            if (!vecs[i].err)
                check($sformatf("v%0d_mem_addr", i), acc_addr, {22'h0, vecs[i].ad[11:2]});
            if (vecs[i].nwe != 0)
                check($sformatf("v%0d_mem_wdata", i), we_data, vecs[i].ewd);
        end

        // Reset dropped during RMW_WR, before the write edge
        @(negedge clk);
        req_write = 1'b1; req_size = 2'd1; req_signed = 1'b0;
        req_addr = 32'h10; req_wdata = 32'h0000BEEF; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("rmwrst_rd_phase_re", {31'h0, mem_re}, 32'h1);
        @(negedge clk);
        check("rmwrst_wr_phase_we", {31'h0, mem_we}, 32'h1);
        #1 rst_n = 1'b0;
        #1;
        check("rmwrst_we_drop", {31'h0, mem_we},    32'h0);
        check("rmwrst_ready",   {31'h0, req_ready}, 32'h1);
        rst_resp = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (resp_valid) rst_resp++;
            if (c == 1) rst_n = 1'b1;
        end
        check("rmwrst_no_resp", rst_resp, 0);
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd, er, lat, nwe, nre, acc_addr, we_data);
        check("rmwrst_mem_unchanged", rd, 32'h7FFE33AA);

        // Handshake: request held valid across three back-to-back loads
        hs_addr[0] = 32'h10; hs_addr[1] = 32'h11; hs_addr[2] = 32'h12;
        hs_exp[0]  = 32'h7F; hs_exp[1]  = 32'hFE; hs_exp[2]  = 32'h33;
        pulses = 0; last = -100; mingap = 1000; accepted = 0; bad_ready = 0;
        @(negedge clk);
        req_write = 1'b0; req_size = 2'd0; req_signed = 1'b0;
        req_addr = hs_addr[0]; req_valid = 1'b1;
        for (int c = 0; c < 30; c++) begin
            logic acc;
            if (resp_valid) begin
                if (c - last < mingap) mingap = c - last;
                last = c;
                if (pulses < 3)
                    check($sformatf("hs_rdata%0d", pulses), resp_rdata, hs_exp[pulses]);
                pulses++;
            end
            if (req_ready && (mem_we || mem_re || resp_valid)) bad_ready++;
            acc = req_ready && req_valid;
            @(negedge clk);
            if (acc) begin
                accepted++;
                if (accepted == 3) req_valid = 1'b0;
                else req_addr = hs_addr[accepted];
            end
        end
        check("hs_pulses",    pulses,    3);
        check("hs_min_gap",   {31'h0, mingap >= 3}, 32'h1);
        check("hs_ready_idle_only", bad_ready, 0);
        check("never_both_strobes", both_strobes, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
